// File: rtl/controle_execucao_pkg.sv
// Shared definitions for the MIPS execution sequencer.
// Holds the state encoding used by the controller and exported on the estado port.
package controle_execucao_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        INICIO     = 3'd0,
        EXECUTA    = 3'd1,
        PASSO      = 3'd2,
        ESPERA_IN  = 3'd3,
        MOSTRA_OUT = 3'd4,
        PARADO     = 3'd5
    } estado_t;

endpackage

// File: rtl/debounce_pulso.sv
// Button conditioner: 2-flop synchronizer, stability filter and rising-edge pulse.
// A raw press shows up as a one-cycle pulso DEB_CYCLES+3 cycles later.
module debounce_pulso #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic nivel,
    output logic pulso
);

    logic        sync1_q;
    logic        sync2_q;
    logic        nivel_q;
    logic        nivelAnt_q;
    logic        pulso_q;
    logic [15:0] estavel_q;
    logic [15:0] estavel_d;
    logic        nivel_d;

    // The level only flips after the synced input has disagreed with it for DEB_CYCLES cycles in a row.
    always_comb begin
        estavel_d = '0;
        nivel_d   = nivel_q;
        if (sync2_q != nivel_q) begin
            if (estavel_q >= DEB_CYCLES - 16'd1) begin
                nivel_d = sync2_q;
            end else begin
                estavel_d = estavel_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            nivel_q    <= 1'b0;
            nivelAnt_q <= 1'b0;
            pulso_q    <= 1'b0;
            estavel_q  <= '0;
        end else begin
            sync1_q    <= botao;
            sync2_q    <= sync1_q;
            nivel_q    <= nivel_d;
            estavel_q  <= estavel_d;
            nivelAnt_q <= nivel_q;
            pulso_q    <= nivel_q & ~nivelAnt_q;
        end
    end

    assign nivel = nivel_q;
    assign pulso = pulso_q;

endmodule

// File: rtl/controle_execucao.sv
// Execution sequencer for the single-cycle MIPS core: decides when an instruction commits
// (exec_en), handling free run, single step, input waits, output display hold and halt.
module controle_execucao
    import controle_execucao_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES  = 16'd50000,
    parameter logic [31:0] HOLD_CYCLES = 32'd50000000,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 congela,
    input  logic                 modo_passo,
    input  logic                 botao_passo,
    input  logic                 botao_confirma,
    input  logic                 halt,
    input  logic                 in,
    input  logic                 out,
    output logic                 exec_en,
    output logic                 esperando_entrada,
    output logic                 mostrando_saida,
    output logic                 processador_parado,
    output logic [ESTADO_W-1:0]  estado,
    output logic [CNT_WIDTH-1:0] contador_instr
);

    estado_t              estado_q;
    estado_t              retorno;
    logic [31:0]          hold_q;
    logic [CNT_WIDTH-1:0] contador_q;
    logic [CNT_WIDTH-1:0] contador_d;
    logic                 passoPulso;
    logic                 confirmaPulso;
    logic [1:0]           niveis_unused;
    logic                 execEn;

    debounce_pulso #(.DEB_CYCLES(DEB_CYCLES)) u_passo (
        .clock (clock),
        .reset (reset),
        .botao (botao_passo),
        .nivel (niveis_unused[0]),
        .pulso (passoPulso)
    );

    debounce_pulso #(.DEB_CYCLES(DEB_CYCLES)) u_confirma (
        .clock (clock),
        .reset (reset),
        .botao (botao_confirma),
        .nivel (niveis_unused[1]),
        .pulso (confirmaPulso)
    );

    assign retorno = modo_passo ? PASSO : EXECUTA;

    // Commit decision is Mealy; reset and freeze both veto it so nothing is written in those cycles.
    always_comb begin
        execEn = 1'b0;
        if (!reset && !congela) begin
            case (estado_q)
                EXECUTA:   execEn = !halt && !in;
                PASSO:     execEn = passoPulso && !halt && !in;
                ESPERA_IN: execEn = confirmaPulso;
                default:   execEn = 1'b0;
            endcase
        end
    end

    always_comb begin
        contador_d = contador_q;
        if (execEn && (contador_q != '1)) begin
            contador_d = contador_q + 1'b1;
        end
    end

    // Pulses that arrive in a state that does not use them simply fall through, so nothing is queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIO;
            hold_q     <= '0;
            contador_q <= '0;
        end else if (!congela) begin
            contador_q <= contador_d;
            case (estado_q)
                INICIO: estado_q <= retorno;
                EXECUTA, PASSO: begin
                    if ((estado_q == EXECUTA) || passoPulso) begin
                        if (halt) begin
                            estado_q <= PARADO;
                        end else if (in) begin
                            estado_q <= ESPERA_IN;
                        end else if (out) begin
                            hold_q   <= HOLD_CYCLES - 32'd1;
                            estado_q <= MOSTRA_OUT;
                        end else if (estado_q == EXECUTA) begin
                            estado_q <= retorno;
                        end else begin
                            estado_q <= PASSO;
                        end
                    end else begin
                        estado_q <= retorno;
                    end
                end
                ESPERA_IN: begin
                    if (confirmaPulso) begin
                        estado_q <= retorno;
                    end
                end
                MOSTRA_OUT: begin
                    if (hold_q == '0) begin
                        estado_q <= retorno;
                    end else begin
                        hold_q <= hold_q - 32'd1;
                    end
                end
                PARADO:  estado_q <= PARADO;
                default: estado_q <= INICIO;
            endcase
        end
    end

    assign exec_en            = execEn;
    assign estado             = estado_q;
    assign contador_instr     = contador_q;
    assign esperando_entrada  = (estado_q == ESPERA_IN);
    assign mostrando_saida    = (estado_q == MOSTRA_OUT);
    assign processador_parado = (estado_q == PARADO);

endmodule

// File: tb/tb_controle_execucao.sv
// Self-checking bench for controle_execucao: directed scenarios plus random traffic,
// every cycle compared against a cycle-level behavioural model of the sequencer.
module tb_controle_execucao;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    localparam int S_INICIO = 0;
    localparam int S_EXEC   = 1;
    localparam int S_PASSO  = 2;
    localparam int S_ESPERA = 3;
    localparam int S_MOSTRA = 4;
    localparam int S_PARADO = 5;

    logic          clock = 1'b0;
    logic          rRes, rCong, rModo, rBp, rBc, rHalt, rIn, rOut;
    logic          wExec, wEspera, wShow, wParado;
    logic [2:0]    wEstado;
    logic [CW-1:0] wCnt;

    int checks = 0;
    int failures = 0;
    int cycNum = 0;
    int execSeen = 0;
    int showSeen = 0;
    int lastExecCyc = 0;

    int mSt, mShowLeft, mCnt;
    bit mLvl[2], mLvlPrev[2], mPulse[2];
    int mRun[2];
    bit histP[$];
    bit histC[$];

    controle_execucao #(
        .DEB_CYCLES  (16'd4),
        .HOLD_CYCLES (32'd8),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock              (clock),
        .reset              (rRes),
        .congela            (rCong),
        .modo_passo         (rModo),
        .botao_passo        (rBp),
        .botao_confirma     (rBc),
        .halt               (rHalt),
        .in                 (rIn),
        .out                (rOut),
        .exec_en            (wExec),
        .esperando_entrada  (wEspera),
        .mostrando_saida    (wShow),
        .processador_parado (wParado),
        .estado             (wEstado),
        .contador_instr     (wCnt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cycNum);
        end
    endtask

    task automatic modelReset();
        mSt = S_INICIO;
        mShowLeft = 0;
        mCnt = 0;
        for (int b = 0; b < 2; b++) begin
            mLvl[b] = 0;
            mLvlPrev[b] = 0;
            mPulse[b] = 0;
            mRun[b] = 0;
        end
        histP = {1'b0, 1'b0};
        histC = {1'b0, 1'b0};
    endtask

    function automatic bit modelExec();
        if (rRes || rCong) return 0;
        case (mSt)
            S_EXEC:   return !rHalt && !rIn;
            S_PASSO:  return mPulse[0] && !rHalt && !rIn;
            S_ESPERA: return mPulse[1];
            default:  return 0;
        endcase
    endfunction

    // A button level is accepted once the synced input disagreed with it DEB times in a row.
    task automatic modelDebounce(input int b, input bit sample);
        bit newPulse;
        newPulse = mLvl[b] && !mLvlPrev[b];
        mLvlPrev[b] = mLvl[b];
        if (sample != mLvl[b]) begin
            mRun[b]++;
            if (mRun[b] >= DEB) begin
                mLvl[b] = sample;
                mRun[b] = 0;
            end
        end else begin
            mRun[b] = 0;
        end
        mPulse[b] = newPulse;
    endtask

    task automatic modelStep();
        bit ex, sP, sC;
        int ret;
        if (rRes) begin
            modelReset();
            return;
        end
        ex = modelExec();
        ret = rModo ? S_PASSO : S_EXEC;
        if (!rCong) begin
            if (ex && mCnt < CMAX) mCnt++;
            case (mSt)
                S_INICIO: mSt = ret;
                S_EXEC, S_PASSO: begin
                    if (mSt == S_EXEC || mPulse[0]) begin
                        if (rHalt) mSt = S_PARADO;
                        else if (rIn) mSt = S_ESPERA;
                        else if (rOut) begin
                            mSt = S_MOSTRA;
                            mShowLeft = HOLD;
                        end else if (mSt == S_EXEC) mSt = ret;
                        else mSt = S_PASSO;
                    end else begin
                        mSt = ret;
                    end
                end
                S_ESPERA: if (mPulse[1]) mSt = ret;
                S_MOSTRA: begin
                    mShowLeft--;
                    if (mShowLeft == 0) mSt = ret;
                end
                default: ;
            endcase
        end
        sP = histP.pop_front();
        histP.push_back(rBp);
        sC = histC.pop_front();
        histC.push_back(rBc);
        modelDebounce(0, sP);
        modelDebounce(1, sC);
    endtask

    // Inputs are set at the falling edge; outputs are compared just after it, then the model advances.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            checkOutput("exec_en", wExec, modelExec());
            checkOutput("estado", wEstado, mSt);
            checkOutput("contador", wCnt, mCnt);
            checkOutput("esperando", wEspera, mSt == S_ESPERA);
            checkOutput("mostrando", wShow, mSt == S_MOSTRA);
            checkOutput("parado", wParado, mSt == S_PARADO);
            execSeen += wExec;
            showSeen += wShow;
            if (wExec) lastExecCyc = cycNum;
            cycNum++;
            modelStep();
            @(negedge clock);
        end
    endtask

    initial begin
        int pressCyc;
        int bpLeft;
        int bcLeft;
        rRes = 1; rCong = 0; rModo = 0; rBp = 0; rBc = 0; rHalt = 0; rIn = 0; rOut = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        modelReset();
        applyStimulus(2);

        // Free run, then halt
        rRes = 0;
        applyStimulus(11);
        checkOutput("cnt10", wCnt, 10);
        rHalt = 1;
        applyStimulus(6);
        checkOutput("haltParado", wParado, 1);
        checkOutput("haltCntFrozen", wCnt, 10);

        // in instruction waits for confirm
        rHalt = 0; rRes = 1;
        applyStimulus(1);
        rRes = 0; rIn = 1;
        applyStimulus(30);
        execSeen = 0;
        pressCyc = cycNum;
        rBc = 1;
        applyStimulus(10);
        rBc = 0;
        applyStimulus(10);
        checkOutput("inOneCommit", execSeen, 1);
        checkOutput("inLatency", lastExecCyc - pressCyc, 7);

        // out instruction holds the display
        rIn = 0; rRes = 1;
        applyStimulus(1);
        rRes = 0;
        applyStimulus(3);
        rOut = 1;
        applyStimulus(1);
        rOut = 0; showSeen = 0; execSeen = 0;
        applyStimulus(8);
        checkOutput("outHold", showSeen, 8);
        checkOutput("outNoCommit", execSeen, 0);
        applyStimulus(2);
        checkOutput("outResume", execSeen, 2);

        // Single step
        rModo = 1; rRes = 1;
        applyStimulus(1);
        rRes = 0; execSeen = 0;
        applyStimulus(20);
        checkOutput("stepIdle", execSeen, 0);
        for (int k = 0; k < 2; k++) begin
            execSeen = 0;
            rBp = 1;
            applyStimulus(8);
            rBp = 0;
            applyStimulus(12);
            checkOutput("stepClean", execSeen, 1);
        end
        execSeen = 0;
        for (int k = 0; k < 6; k++) begin
            rBp = ~rBp;
            applyStimulus(2);
        end
        applyStimulus(6);
        checkOutput("bounceNone", execSeen, 0);
        rBp = 1;
        applyStimulus(10);
        rBp = 0;
        applyStimulus(8);
        checkOutput("bounceStable", execSeen, 1);

        // Freeze during the display hold, with a step press dropped
        rModo = 0; rRes = 1;
        applyStimulus(1);
        rRes = 0;
        applyStimulus(3);
        rOut = 1;
        applyStimulus(1);
        rOut = 0; showSeen = 0; execSeen = 0;
        applyStimulus(3);
        rModo = 1; rCong = 1;
        applyStimulus(2);
        rBp = 1;
        applyStimulus(8);
        rBp = 0;
        applyStimulus(10);
        rCong = 0;
        applyStimulus(15);
        checkOutput("freezeHold", showSeen, 28);
        checkOutput("freezeDrop", execSeen, 0);
        checkOutput("freezeEnd", wEstado, S_PASSO);

        // Reset in the middle of waits
        rModo = 0; rRes = 1;
        applyStimulus(1);
        rRes = 0;
        applyStimulus(5);
        rIn = 1;
        applyStimulus(4);
        rRes = 1;
        applyStimulus(1);
        rRes = 0; rIn = 0;
        checkOutput("rstInEst", wEstado, 0);
        checkOutput("rstInCnt", wCnt, 0);
        applyStimulus(4);
        rOut = 1;
        applyStimulus(1);
        rOut = 0;
        applyStimulus(3);
        rRes = 1;
        applyStimulus(1);
        rRes = 0;
        checkOutput("rstOutEst", wEstado, 0);
        checkOutput("rstOutCnt", wCnt, 0);
        applyStimulus(4);
        rRes = 1;
        #1;
        checkOutput("rstNoCommit", wExec, 0);
        applyStimulus(1);
        rRes = 0;

        // Counter saturation
        applyStimulus(80);
        checkOutput("cntSat", wCnt, CMAX);

        // Random traffic
        bpLeft = 0;
        bcLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            rRes = ($urandom_range(0, 199) == 0);
            if (rCong) rCong = ($urandom_range(0, 4) != 0);
            else rCong = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) rModo = ~rModo;
            if (bpLeft == 0) begin
                rBp = 1'($urandom_range(0, 1));
                bpLeft = $urandom_range(1, 14);
            end
            if (bcLeft == 0) begin
                rBc = 1'($urandom_range(0, 1));
                bcLeft = $urandom_range(1, 14);
            end
            bpLeft--;
            bcLeft--;
            rHalt = ($urandom_range(0, 299) == 0);
            rIn = ($urandom_range(0, 7) == 0);
            rOut = ($urandom_range(0, 7) == 0);
            applyStimulus(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_execucao.md
Name: controle_execucao

Overview:
- Execution sequencer for the single-cycle MIPS core.
- Produces exec_en, a per-instruction commit enable that gates PC update, register-bank write and RAM write.
- Implements free-run and single-step modes, stalls on `in` instructions until the user confirms the switch value, and holds `out` results on the 7-segment display for a fixed time.
- Stops permanently on `halt`. Sits between the board buttons/switches, the control unit (halt/in/out) and the datapath write enables.

Parameters:
- DEB_CYCLES, 16'd50000, clock cycles a synchronized button level must stay stable before it is accepted (minimum 1).
- HOLD_CYCLES, 32'd50000000, cycles MOSTRA_OUT holds before execution resumes (minimum 1).
- CNT_WIDTH, 32, width of the instruction counter.

Ports:
- clock  in  1  system clock (divided clock)
- reset  in  1  synchronous, active-high
- congela  in  1  freeze: no transitions, no commits, counters paused
- modo_passo  in  1  1 = single-step mode, 0 = free run
- botao_passo  in  1  raw step button, asynchronous, active-high
- botao_confirma  in  1  raw input-confirm button, asynchronous, active-high
- halt  in  1  control-unit decode of the current instruction
- in  in  1  control-unit decode of the current instruction
- out  in  1  control-unit decode of the current instruction
- exec_en  out  1  commit the current instruction this cycle
- esperando_entrada  out  1  high in ESPERA_IN
- mostrando_saida  out  1  high in MOSTRA_OUT
- processador_parado  out  1  high in PARADO
- estado  out  3  current state encoding
- contador_instr  out  CNT_WIDTH  number of committed instructions

Behaviour:
- Reset (synchronous): estado=INICIO, contador_instr=0, hold counter=0, debouncers cleared (level=0, no pulse). All outputs are 0 at reset.
- State encodings: INICIO=0, EXECUTA=1, PASSO=2, ESPERA_IN=3, MOSTRA_OUT=4, PARADO=5. Codes 6 and 7 go to INICIO.
- exec_en is Mealy: combinational from the registered state, the decode inputs and the step/confirm pulses. The PC changes only when exec_en=1, so the decode inputs are stable while the controller waits.
- Button path: 2-flop synchronizer, then a stability counter. The debounced level updates once the synced level has differed from it for DEB_CYCLES consecutive cycles. A rising edge of the debounced level produces a 1-cycle pulse. Latency from raw press to pulse is DEB_CYCLES+3 cycles.
- INICIO: exec_en=0. Next state is PASSO if modo_passo=1, otherwise EXECUTA.
- EXECUTA, evaluated each cycle:
  - halt: exec_en=0, go to PARADO.
  - else in: exec_en=0, go to ESPERA_IN.
  - else out: exec_en=1, load hold counter with HOLD_CYCLES-1, go to MOSTRA_OUT.
  - else: exec_en=1; stay in EXECUTA, or go to PASSO if modo_passo=1.
- PASSO: exec_en=0 until a step pulse arrives. On the pulse, apply the EXECUTA decision table once, with the next state being PASSO instead of EXECUTA. With no pulse, go to EXECUTA if modo_passo=0.
- ESPERA_IN: exec_en=0 until a confirm pulse arrives. On the pulse, exec_en=1 (the write-back takes the switch value) and go to PASSO or EXECUTA per modo_passo.
- MOSTRA_OUT: hold counter decrements each cycle. When it is 0, go to PASSO or EXECUTA per modo_passo. exec_en=0 throughout.
- PARADO: sticky until reset. exec_en=0.
- Decode priority is halt > in > out when several are asserted.
- congela=1 overrides every state:
  - exec_en=0; state, hold counter and contador_instr are held.
  - Debouncers keep running, but any step/confirm pulse that occurs while congela=1 is discarded.
- contador_instr increments on every cycle with exec_en=1 and saturates at all-ones.
- Step and confirm pulses arriving in states that do not consume them are ignored. They are never queued.
- Reset asserted mid-wait or mid-hold returns to INICIO on the next edge. No commit happens in the reset cycle.

Decomposition:
- Package controle_execucao_pkg: state encoding localparams (INICIO..PARADO) and the estado width of 3.
- Sub-module debounce_pulso (parameter DEB_CYCLES; ports clock, reset, botao, nivel, pulso), instantiated twice: once for step, once for confirm.
- The FSM, hold counter and instruction counter stay in the top module.

Test Plan:
1. Free run, DEB_CYCLES=4, HOLD_CYCLES=8, plain instructions (halt/in/out=0):
   - reset released at cycle 0 → estado=1 at cycle 1, exec_en=1 every cycle from cycle 1, contador_instr=10 after cycle 10.
   - Then halt=1 → exec_en=0, estado=5, processador_parado=1, counter frozen.
2. in instruction in free run:
   - exec_en=0, esperando_entrada=1 indefinitely.
   - botao_confirma high for 10 cycles → exactly one exec_en pulse 7 cycles after the press, then estado=1.
3. out instruction:
   - one exec_en cycle, then mostrando_saida=1 for exactly 8 cycles with exec_en=0, then exec_en resumes.
4. Single step, modo_passo=1:
   - no commits without presses; each clean press → exactly one exec_en pulse.
   - a bouncing press (toggles every 2 cycles, shorter than DEB_CYCLES) → no pulse until stable.
5. congela=1 held for 20 cycles during MOSTRA_OUT:
   - hold counter and estado frozen; a step press during the freeze is dropped.
   - after release, the remaining hold cycles complete exactly.
6. Reset asserted during ESPERA_IN and during MOSTRA_OUT:
   - next cycle estado=0, contador_instr=0, exec_en=0 in the reset cycle.
